loadable_down_timer: RTL and testbench

//  Loadable down-counting timer; the decrementing counterpart to the team's loadable up-counter.

---
 rtl/loadable_down_timer.sv | 78 +++++++
 tb/tb_loadable_down_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/loadable_down_timer.sv
// Loadable down-counting timer with a one-cycle expire pulse and optional auto-reload.
// Two-state FSM (IDLE/RUN); count, reload value and expire pulse are all registered.
module loadable_down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             reload_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             expire_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;
    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && (count_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (!pause_i) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Expiry edge: reload keeps running so count_o never shows 0.
              expire_d = 1'b1;
              if (reload_en_i) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_o  = count_q;
  assign busy_o   = (state_q == RUN);
  assign expire_o = expire_q;

endmodule

// File: tb/tb_loadable_down_timer.sv
// Self-checking bench for loadable_down_timer: directed scenarios with literal expectations,
// then random stimulus compared every cycle against a behavioural model.
module tb_loadable_down_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_i = 1'b0;
  logic [WIDTH-1:0] load_val_i = '0;
  logic             start_i = 1'b0;
  logic             pause_i = 1'b0;
  logic             reload_en_i = 1'b0;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             expire_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Behavioural model: remaining count, period memory, running flag, pulse.
  int m_count = 0;
  int m_period = 0;
  bit m_running = 1'b0;
  bit m_expire = 1'b0;

  loadable_down_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .start_i    (start_i),
    .pause_i    (pause_i),
    .reload_en_i(reload_en_i),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .expire_o   (expire_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_expire = 1'b0;
    if (reset) begin
      m_count = 0; m_period = 0; m_running = 1'b0;
    end else if (load_i) begin
      m_count = int'(load_val_i); m_period = int'(load_val_i); m_running = 1'b0;
    end else if (!m_running) begin
      m_running = start_i && (m_count > 0);
    end else if (!pause_i) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_expire = 1'b1;
        if (reload_en_i) m_count = m_period;
        else m_running = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (int'(count_o) != m_count || busy_o !== m_running || expire_o !== m_expire) begin
        miscompares++;
        $display("FAIL model t=%0t count=%0d busy=%0b exp=%0b required count=%0d busy=%0b exp=%0b",
                 $time, count_o, busy_o, expire_o, m_count, m_running, m_expire);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int cnt, input bit busy, input bit exp);
    vectors++;
    if (int'(count_o) != cnt || busy_o !== busy || expire_o !== exp) begin
      miscompares++;
      $display("FAIL %s count=%0d busy=%0b exp=%0b required count=%0d busy=%0b exp=%0b",
               name, count_o, busy_o, expire_o, cnt, busy, exp);
    end
  endtask

  task automatic load_start(input int val);
    load_i = 1'b1; load_val_i = WIDTH'(val); step();
    load_i = 1'b0; start_i = 1'b1; step();
    start_i = 1'b0;
  endtask

  initial begin
    // 1: reset, then start with count 0 is ignored
    reset = 1'b1; step(); step();
    chk_en = 1'b1;
    reset = 1'b0; step();
    check("reset", 0, 1'b0, 1'b0);
    start_i = 1'b1; step(); start_i = 1'b0;
    check("start_zero", 0, 1'b0, 1'b0);

    // 2: one-shot countdown from 5
    reload_en_i = 1'b0;
    load_start(5);
    check("oneshot_start", 5, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      step(); check("oneshot_dec", k, 1'b1, 1'b0);
    end
    step(); check("oneshot_expire", 0, 1'b0, 1'b1);
    step(); check("oneshot_after", 0, 1'b0, 1'b0);

    // 3: periodic reload of 3
    reload_en_i = 1'b1;
    load_start(3);
    check("reload_start", 3, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      step(); check("reload_2", 2, 1'b1, 1'b0);
      step(); check("reload_1", 1, 1'b1, 1'b0);
      step(); check("reload_wrap", 3, 1'b1, 1'b1);
    end
    reload_en_i = 1'b0;
    step(); step(); step();
    check("reload_stop", 0, 1'b0, 1'b1);

    // 4: pause at 4
    load_start(6);
    step(); step();
    check("pause_pre", 4, 1'b1, 1'b0);
    pause_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); check("pause_hold", 4, 1'b1, 1'b0);
    end
    pause_i = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      step(); check("pause_resume", k, 1'b1, 1'b0);
    end
    step(); check("pause_expire", 0, 1'b0, 1'b1);

    // 5: load aborts a run, same-cycle start ignored
    load_start(7);
    for (int k = 0; k < 5; k++) step();
    check("abort_pre", 2, 1'b1, 1'b0);
    load_i = 1'b1; load_val_i = 4'd9; start_i = 1'b1; step();
    load_i = 1'b0; start_i = 1'b0;
    check("abort_load", 9, 1'b0, 1'b0);
    start_i = 1'b1; step(); start_i = 1'b0;
    check("abort_restart", 9, 1'b1, 1'b0);
    step(); check("abort_dec", 8, 1'b1, 1'b0);

    // 6: reset mid-run from max load
    load_start(15);
    for (int k = 0; k < 5; k++) step();
    check("rst_pre", 10, 1'b1, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid", 0, 1'b0, 1'b0);
    start_i = 1'b1; step(); start_i = 1'b0;
    check("rst_start_ign", 0, 1'b0, 1'b0);

    // Random phase: every cycle checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      load_i      = ($urandom_range(0, 15) == 0);
      load_val_i  = WIDTH'($urandom);
      start_i     = ($urandom_range(0, 3) == 0);
      pause_i     = ($urandom_range(0, 3) == 0);
      reload_en_i = ($urandom_range(0, 1) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
